// File: rtl/healthcare_alarm_responder.sv
// Ward alarm responder: latches the most severe warning code, drives buzzer/nurse-call, escalates
// on ack timeout. Optional HEALTHCARE_ALARM_EVENT_COUNT_EN adds a saturating alarm-entry counter.
module healthcare_alarm_responder #(
    parameter int unsigned BEEP_PERIOD = 4,
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CLEAR_HOLD  = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [2:0] abnormalityWarning,
    input  logic       nurseAck,
    output logic [2:0] ledCode,
    output logic       buzzer,
    output logic       callNurse,
    output logic       escalate,
    output logic       alarmActive
`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
    ,
    output logic [7:0] eventCount
`endif
);

    localparam int unsigned BeepW = $clog2(BEEP_PERIOD) + 1;
    localparam int unsigned ToW   = $clog2(ACK_TIMEOUT) + 1;
    localparam int unsigned ClrW  = $clog2(CLEAR_HOLD) + 1;

    typedef enum logic [1:0] {
        StIdle,
        StAlert,
        StEscalated,
        StAcked
    } alarmStateT;

    alarmStateT       stateQ, stateD;
    logic [2:0]       warnReg;
    logic [2:0]       ledCodeQ, ledCodeD;
    logic [ToW-1:0]   toCntQ, toCntD;
    logic [BeepW-1:0] beepCntQ, beepCntD;
    logic [ClrW-1:0]  clrCntQ, clrCntD;
    logic             buzzerQ, buzzerD;
    logic             callNurseQ, callNurseD;
    logic             escalateQ, escalateD;
    logic             alarmActiveQ, alarmActiveD;
    logic             enterAlert;
    logic             higherCode;

    assign higherCode = warnReg > ledCodeQ;

    always_comb begin
        stateD     = stateQ;
        ledCodeD   = ledCodeQ;
        toCntD     = toCntQ;
        beepCntD   = beepCntQ;
        clrCntD    = clrCntQ;
        buzzerD    = buzzerQ;
        enterAlert = 1'b0;

        unique case (stateQ)
            StIdle: begin
                buzzerD = 1'b0;
                if (warnReg != 3'd0) begin
                    stateD     = StAlert;
                    ledCodeD   = warnReg;
                    toCntD     = '0;
                    beepCntD   = '0;
                    buzzerD    = 1'b1;
                    enterAlert = 1'b1;
                end
            end
            StAlert: begin
                if (beepCntQ == BeepW'(BEEP_PERIOD - 1)) begin
                    beepCntD = '0;
                    buzzerD  = ~buzzerQ;
                end else begin
                    beepCntD = beepCntQ + 1'b1;
                end
                // A more severe code outranks both ack and timeout and restarts the ack window.
                if (higherCode) begin
                    ledCodeD = warnReg;
                    toCntD   = '0;
                end else if (nurseAck) begin
                    stateD  = StAcked;
                    clrCntD = '0;
                    buzzerD = 1'b0;
                end else if (toCntQ == ToW'(ACK_TIMEOUT - 1)) begin
                    stateD  = StEscalated;
                    buzzerD = 1'b1;
                end else begin
                    toCntD = toCntQ + 1'b1;
                end
            end
            StEscalated: begin
                buzzerD = 1'b1;
                if (higherCode) begin
                    ledCodeD = warnReg;
                end else if (nurseAck) begin
                    stateD  = StAcked;
                    clrCntD = '0;
                    buzzerD = 1'b0;
                end
            end
            StAcked: begin
                buzzerD = 1'b0;
                if (higherCode) begin
                    stateD     = StAlert;
                    ledCodeD   = warnReg;
                    toCntD     = '0;
                    beepCntD   = '0;
                    buzzerD    = 1'b1;
                    enterAlert = 1'b1;
                end else if (warnReg == 3'd0) begin
                    if (clrCntQ == ClrW'(CLEAR_HOLD - 1)) begin
                        stateD   = StIdle;
                        ledCodeD = 3'd0;
                        clrCntD  = '0;
                    end else begin
                        clrCntD = clrCntQ + 1'b1;
                    end
                end else begin
                    clrCntD = '0;
                end
            end
            default: begin
                stateD = StIdle;
            end
        endcase

        callNurseD   = (stateD == StAlert) || (stateD == StEscalated);
        escalateD    = stateD == StEscalated;
        alarmActiveD = stateD != StIdle;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stateQ       <= StIdle;
            warnReg      <= 3'd0;
            ledCodeQ     <= 3'd0;
            toCntQ       <= '0;
            beepCntQ     <= '0;
            clrCntQ      <= '0;
            buzzerQ      <= 1'b0;
            callNurseQ   <= 1'b0;
            escalateQ    <= 1'b0;
            alarmActiveQ <= 1'b0;
        end else begin
            stateQ       <= stateD;
            warnReg      <= abnormalityWarning;
            ledCodeQ     <= ledCodeD;
            toCntQ       <= toCntD;
            beepCntQ     <= beepCntD;
            clrCntQ      <= clrCntD;
            buzzerQ      <= buzzerD;
            callNurseQ   <= callNurseD;
            escalateQ    <= escalateD;
            alarmActiveQ <= alarmActiveD;
        end
    end

    assign ledCode     = ledCodeQ;
    assign buzzer      = buzzerQ;
    assign callNurse   = callNurseQ;
    assign escalate    = escalateQ;
    assign alarmActive = alarmActiveQ;

`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
    logic [7:0] eventCountQ;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            eventCountQ <= 8'd0;
        end else if (enterAlert && (eventCountQ != 8'hFF)) begin
            eventCountQ <= eventCountQ + 8'd1;
        end
    end

    assign eventCount = eventCountQ;
`else
    logic unusedEnterAlert;
    assign unusedEnterAlert = enterAlert;
`endif

endmodule

// File: tb/tb_healthcare_alarm_responder.sv
// Self-checking bench for healthcare_alarm_responder: directed scenarios plus randomized
// stimulus against a timestamp-based behavioural model.
module tb_healthcare_alarm_responder;

    localparam int BP = 4;
    localparam int TO = 16;
    localparam int CH = 3;

    localparam int MIdle  = 0;
    localparam int MAlert = 1;
    localparam int MEsc   = 2;
    localparam int MAcked = 3;

    logic       clock;
    logic       resetn;
    logic [2:0] abnormalityWarning;
    logic       nurseAck;
    logic [2:0] ledCode;
    logic       buzzer;
    logic       callNurse;
    logic       escalate;
    logic       alarmActive;
`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
    logic [7:0] eventCount;
`endif

    healthcare_alarm_responder #(
        .BEEP_PERIOD(BP),
        .ACK_TIMEOUT(TO),
        .CLEAR_HOLD (CH)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .abnormalityWarning(abnormalityWarning),
        .nurseAck          (nurseAck),
        .ledCode           (ledCode),
        .buzzer            (buzzer),
        .callNurse         (callNurse),
        .escalate          (escalate),
        .alarmActive       (alarmActive)
`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
        ,
        .eventCount        (eventCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: alarm timing expressed as edge timestamps rather than counters.
    int mMode, mWarn, mLed, mEvents, zeroRun;
    int edgeN, armEdge, beepEdge;

    task automatic checkEq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edgeN);
        end
    endtask

    task automatic modelReset();
        mMode = MIdle; mWarn = 0; mLed = 0; mEvents = 0; zeroRun = 0;
        edgeN = 0; armEdge = 0; beepEdge = 0;
    endtask

    task automatic modelStep(input int w, input int ack);
        int code;
        edgeN++;
        code  = mWarn;
        mWarn = w;
        case (mMode)
            MIdle: if (code != 0) begin
                mMode = MAlert; mLed = code; armEdge = edgeN; beepEdge = edgeN; mEvents++;
            end
            MAlert: begin
                if (code > mLed) begin
                    mLed = code; armEdge = edgeN;
                end else if (ack != 0) begin
                    mMode = MAcked; zeroRun = 0;
                end else if (edgeN - armEdge == TO) begin
                    mMode = MEsc;
                end
            end
            MEsc: begin
                if (code > mLed) mLed = code;
                else if (ack != 0) begin mMode = MAcked; zeroRun = 0; end
            end
            default: begin
                if (code > mLed) begin
                    mMode = MAlert; mLed = code; armEdge = edgeN; beepEdge = edgeN; mEvents++;
                end else if (code == 0) begin
                    zeroRun++;
                    if (zeroRun == CH) begin mMode = MIdle; mLed = 0; end
                end else begin
                    zeroRun = 0;
                end
            end
        endcase
        if (mEvents > 255) mEvents = 255;
    endtask

    task automatic checkOutputs();
        int expBuzz;
        if (mMode == MAlert) expBuzz = (((edgeN - beepEdge) / BP) % 2 == 0) ? 1 : 0;
        else expBuzz = (mMode == MEsc) ? 1 : 0;
        checkEq("ledCode", int'(ledCode), mLed);
        checkEq("buzzer", int'(buzzer), expBuzz);
        checkEq("callNurse", int'(callNurse), (mMode == MAlert || mMode == MEsc) ? 1 : 0);
        checkEq("escalate", int'(escalate), (mMode == MEsc) ? 1 : 0);
        checkEq("alarmActive", int'(alarmActive), (mMode != MIdle) ? 1 : 0);
`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
        checkEq("eventCount", int'(eventCount), mEvents);
`endif
    endtask

    // Called at a falling edge: drive, clock once, step model, check at next falling edge.
    task automatic cycle(input int w, input int ack);
        abnormalityWarning = 3'(w);
        nurseAck           = (ack != 0);
        @(posedge clock);
        modelStep(w, ack);
        @(negedge clock);
        checkOutputs();
    endtask

    task automatic checkAllZero(input string tag);
        checkEq({tag, "_led"}, int'(ledCode), 0);
        checkEq({tag, "_buzz"}, int'(buzzer), 0);
        checkEq({tag, "_call"}, int'(callNurse), 0);
        checkEq({tag, "_esc"}, int'(escalate), 0);
        checkEq({tag, "_active"}, int'(alarmActive), 0);
    endtask

    task automatic asyncReset();
        resetn = 1'b0;
        #1;
        checkAllZero("midReset");
        modelReset();
        @(negedge clock);
        resetn = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int alertIt, escIt, escSeen;
        resetn             = 1'b0;
        abnormalityWarning = 3'd0;
        nurseAck           = 1'b0;
        modelReset();
        repeat (2) @(negedge clock);
        checkAllZero("reset");
        resetn = 1'b1;

        // Quiet ward.
        for (int i = 0; i < 10; i++) cycle(0, 0);
        checkAllZero("quiet");

        // Code 3: two-cycle latency, beep period, ack, then partial clear and re-alarm.
        cycle(3, 0);
        checkEq("t2_lat1", int'(ledCode), 0);
        cycle(3, 0);
        checkEq("t2_lat2", int'(ledCode), 3);
        for (int i = 0; i < 4; i++) cycle(3, 0);
        checkEq("t2_toggle", int'(buzzer), 0);
        cycle(3, 1);
        checkEq("t2_ackCall", int'(callNurse), 0);
        checkEq("t2_ackBuzz", int'(buzzer), 0);
        cycle(0, 0);
        cycle(0, 0);
        cycle(4, 0);
        cycle(4, 0);
        checkEq("t5_realarmLed", int'(ledCode), 4);
        checkEq("t5_realarmCall", int'(callNurse), 1);
        cycle(0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0);
        checkEq("t5_idleActive", int'(alarmActive), 0);
        checkEq("t5_idleLed", int'(ledCode), 0);

        // No ack: escalation exactly TO cycles after alarm entry.
        alertIt = -1;
        escIt   = -1;
        for (int i = 0; i < 40; i++) begin
            cycle(2, 0);
            if (alertIt < 0 && callNurse) alertIt = i;
            if (escIt < 0 && escalate) escIt = i;
        end
        checkEq("t3_escDelay", escIt - alertIt, TO);
        checkEq("t3_buzzSteady", int'(buzzer), 1);
        cycle(2, 1);
        checkEq("t3_ackEsc", int'(escalate), 0);
        for (int i = 0; i < 5; i++) cycle(0, 0);

        // Raise 2 -> 5 re-arms the timeout; lower code 1 is ignored.
        for (int i = 0; i < 3; i++) cycle(2, 0);
        for (int i = 0; i < 10; i++) cycle(5, 0);
        for (int i = 0; i < 6; i++) cycle(1, 0);
        checkEq("t4_ledHeld", int'(ledCode), 5);
        checkEq("t4_rearmed", int'(escalate), 0);
        cycle(0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0);

        // Ack arriving on the timeout edge wins over escalation.
        escSeen = 0;
        cycle(1, 0);
        for (int i = 0; i < 16; i++) begin
            cycle(1, 0);
            if (escalate) escSeen = 1;
        end
        cycle(1, 1);
        if (escalate) escSeen = 1;
        checkEq("t6_noEsc", escSeen, 0);
        checkEq("t6_acked", int'(alarmActive), 1);
        checkEq("t6_ackCall", int'(callNurse), 0);
        for (int i = 0; i < 4; i++) cycle(0, 0);

        // Randomized segments with occasional asynchronous reset.
        for (int s = 0; s < 300; s++) begin
            int code, len;
            code = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
            len  = int'($urandom_range(1, 20));
            for (int i = 0; i < len; i++) cycle(code, ($urandom_range(0, 19) == 0) ? 1 : 0);
            if ($urandom_range(0, 49) == 0) asyncReset();
        end

`ifdef HEALTHCARE_ALARM_EVENT_COUNT_EN
        asyncReset();
        for (int n = 0; n < 300; n++) begin
            cycle(1, 0);
            cycle(1, 0);
            cycle(0, 1);
            for (int i = 0; i < 3; i++) cycle(0, 0);
        end
        checkEq("eventSaturate", int'(eventCount), 255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
